// File: rtl/bus_arbiter.sv
// Round-robin multi-master front end for the system bus.
// Forwards one transaction at a time to addr_decoder and guards it with a watchdog.
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NUM_MASTERS-1:0]                  m_valid_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
  input  logic [NUM_MASTERS-1:0]                  m_we_i,
  output logic [NUM_MASTERS-1:0]                  m_ready_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_rdata_o,
  output logic [NUM_MASTERS-1:0]                  m_err_o,
  output logic                                    valid_o,
  output logic [ADDR_WIDTH-1:0]                   addr_o,
  output logic [DATA_WIDTH-1:0]                   wdata_o,
  output logic                                    we_o,
  input  logic                                    ready_i,
  input  logic [DATA_WIDTH-1:0]                   rdata_i,
  input  logic                                    err_i,
  output logic [NUM_MASTERS-1:0]                  grant_o,
  output logic                                    timeout_o
);

  localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned WD_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic        WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = '1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic [IDX_W-1:0]       pick_idx, scan_idx;
  logic                   pick_found;
  logic                   busy, g_valid, wd_fire;

  assign grant_o = grant_q;

  // First requester at or after rr_ptr, wrapping past the last master.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    scan_idx   = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_found && m_valid_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    wd_cnt_d  = wd_cnt_q;
    valid_o   = 1'b0;
    addr_o    = '0;
    wdata_o   = '0;
    we_o      = 1'b0;
    m_ready_o = '0;
    m_rdata_o = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;

    busy    = (state_q == S_BUSY);
    g_valid = m_valid_i[gidx_q];
    // A real response or an abort both take precedence over the watchdog.
    wd_fire = WD_EN && busy && g_valid && !ready_i && (wd_cnt_q == WD_W'(WD_LIM));

    if (busy) begin
      valid_o = g_valid && !wd_fire;
      addr_o  = m_addr_i[gidx_q];
      wdata_o = m_wdata_i[gidx_q];
      we_o    = m_we_i[gidx_q];
      if (ready_i) begin
        m_ready_o[gidx_q] = 1'b1;
        m_rdata_o[gidx_q] = rdata_i;
        m_err_o[gidx_q]   = err_i;
      end else if (wd_fire) begin
        m_ready_o[gidx_q] = 1'b1;
        m_err_o[gidx_q]   = 1'b1;
        timeout_o         = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d  = S_BUSY;
          gidx_d   = pick_idx;
          grant_d  = NUM_MASTERS'(1) << pick_idx;
          wd_cnt_d = '0;
        end
      end
      S_BUSY: begin
        if (!ready_i && (wd_cnt_q != WD_MAX)) begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        if (ready_i || wd_fire) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);
        end else if (!g_valid) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter: one table row per clock cycle,
// plus a timeout run and an asynchronous mid-transaction reset.
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int OW = 1 + AW + DW + 1 + NM + NM + NM + NM * DW + 1;

  logic                   clk;
  logic                   rst_i;
  logic [NM-1:0]          m_valid_i;
  logic [NM-1:0][AW-1:0]  m_addr_i;
  logic [NM-1:0][DW-1:0]  m_wdata_i;
  logic [NM-1:0]          m_we_i;
  logic [NM-1:0]          m_ready_o;
  logic [NM-1:0][DW-1:0]  m_rdata_o;
  logic [NM-1:0]          m_err_o;
  logic                   valid_o;
  logic [AW-1:0]          addr_o;
  logic [DW-1:0]          wdata_o;
  logic                   we_o;
  logic                   ready_i;
  logic [DW-1:0]          rdata_i;
  logic                   err_i;
  logic [NM-1:0]          grant_o;
  logic                   timeout_o;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_we_i(m_we_i),
    .m_ready_o(m_ready_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .valid_o(valid_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o),
    .ready_i(ready_i), .rdata_i(rdata_i), .err_i(err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [1:0]    mv;
    logic [1:0]    mwe;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rdy;
    logic [DW-1:0] rd;
    logic          er;
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ewe;
    logic [1:0]    eg, emr, eme;
    logic [DW-1:0] erd0, erd1;
    logic          eto;
  } vec_t;

  function automatic vec_t v(
    input logic rst, input logic [1:0] mv, input logic [1:0] mwe,
    input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
    input logic rdy, input logic [DW-1:0] rd, input logic er,
    input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic ewe,
    input logic [1:0] eg, input logic [1:0] emr, input logic [1:0] eme,
    input logic [DW-1:0] erd0, input logic [DW-1:0] erd1, input logic eto);
    vec_t t;
    t.rst = rst; t.mv = mv; t.mwe = mwe; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.rdy = rdy; t.rd = rd; t.er = er;
    t.ev = ev; t.ea = ea; t.ed = ed; t.ewe = ewe; t.eg = eg; t.emr = emr; t.eme = eme;
    t.erd0 = erd0; t.erd1 = erd1; t.eto = eto;
    return t;
  endfunction

  function automatic logic [OW-1:0] exp_of(input vec_t t);
    return {t.ev, t.ea, t.ed, t.ewe, t.eg, t.emr, t.eme, t.erd1, t.erd0, t.eto};
  endfunction

  // Bus-side addr/wdata/we are only defined while a master is granted or in reset.
  function automatic logic [OW-1:0] mask_of(input vec_t t);
    logic care;
    care = t.rst || (t.eg != 2'b00);
    return {1'b1, {AW{care}}, {DW{care}}, care, {(NM * 3 + NM * DW + 1){1'b1}}};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {valid_o, addr_o, wdata_o, we_o, grant_o, m_ready_o, m_err_o, m_rdata_o, timeout_o};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp, input logic [OW-1:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got %h want %h (mask %h)", name, act, exp, mask);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_i       = t.rst;
    m_valid_i   = t.mv;
    m_we_i      = t.mwe;
    m_addr_i[0] = t.a0;
    m_addr_i[1] = t.a1;
    m_wdata_i[0] = t.d0;
    m_wdata_i[1] = t.d1;
    ready_i     = t.rdy;
    rdata_i     = t.rd;
    err_i       = t.er;
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
  task automatic run_vec(input vec_t t, input string name);
    drive(t);
    @(negedge clk);
    check(name, dut_out(), exp_of(t), mask_of(t));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  vec_t z;

  initial begin
    z = v(0, 2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 0, 8'h0, 0,
          0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h0, 8'h0, 0);
    drive(z);
    rst_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset state with requests pending
    vecs.push_back(v(1, 2'b11, 2'b00, 14'h0500, 14'h0200, 8'h00, 8'h00, 1, 8'hAB, 1, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    // M0 read 0x0500, two wait states, rdata 0xAB
    vecs.push_back(v(0, 2'b01, 2'b00, 14'h0500, 14'h0000, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b01, 2'b00, 14'h0500, 14'h0000, 8'h00, 8'h00, 0, 8'h00, 0, 1, 14'h0500, 8'h00, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b01, 2'b00, 14'h0500, 14'h0000, 8'h00, 8'h00, 0, 8'h00, 0, 1, 14'h0500, 8'h00, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b01, 2'b00, 14'h0500, 14'h0000, 8'h00, 8'h00, 1, 8'hAB, 0, 1, 14'h0500, 8'h00, 0, 2'b01, 2'b01, 2'b00, 8'hAB, 8'h00, 0));
    vecs.push_back(v(0, 2'b00, 2'b00, 14'h0500, 14'h0000, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    // reset, then M0/M1 contend and alternate
    vecs.push_back(v(1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 1, 8'h10, 0, 1, 14'h0100, 8'h11, 0, 2'b01, 2'b01, 2'b00, 8'h10, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 1, 8'h20, 0, 1, 14'h0200, 8'h22, 0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h20, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 1, 8'h30, 0, 1, 14'h0100, 8'h11, 0, 2'b01, 2'b01, 2'b00, 8'h30, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 1, 8'h40, 0, 1, 14'h0200, 8'h22, 0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h40, 0));
    // decoder response while IDLE must not reach any master
    vecs.push_back(v(0, 2'b00, 2'b00, 14'h0100, 14'h0200, 8'h11, 8'h22, 1, 8'hFF, 1, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    // M1 write 0x2800 with same-cycle decode error
    vecs.push_back(v(0, 2'b10, 2'b10, 14'h0000, 14'h2800, 8'h00, 8'h55, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b10, 2'b10, 14'h0000, 14'h2800, 8'h00, 8'h55, 1, 8'h99, 1, 1, 14'h2800, 8'h55, 1, 2'b10, 2'b10, 2'b10, 8'h00, 8'h99, 0));
    vecs.push_back(v(0, 2'b00, 2'b00, 14'h0000, 14'h2800, 8'h00, 8'h55, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    // M0 aborts; rr_ptr must stay on M0
    vecs.push_back(v(0, 2'b01, 2'b00, 14'h0123, 14'h0200, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b01, 2'b00, 14'h0123, 14'h0200, 8'h00, 8'h00, 0, 8'h00, 0, 1, 14'h0123, 8'h00, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b00, 2'b00, 14'h0123, 14'h0200, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0123, 8'h00, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0123, 14'h0200, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 2'b11, 2'b00, 14'h0123, 14'h0200, 8'h00, 8'h00, 1, 8'h77, 0, 1, 14'h0123, 8'h00, 0, 2'b01, 2'b01, 2'b00, 8'h77, 8'h00, 0));
    vecs.push_back(v(0, 2'b00, 2'b00, 14'h0123, 14'h0200, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Watchdog: M0 alone, decoder never answers; fires on BUSY cycle 16.
    run_vec(v(0, 2'b01, 2'b00, 14'h0321, 14'h0200, 8'h00, 8'h00, 0, 8'hEE, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0), "wd_arb");
    for (int k = 1; k <= 15; k++) begin
      run_vec(v(0, 2'b01, 2'b00, 14'h0321, 14'h0200, 8'h00, 8'h00, 0, 8'hEE, 0, 1, 14'h0321, 8'h00, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 0), $sformatf("wd_busy%0d", k));
    end
    run_vec(v(0, 2'b01, 2'b00, 14'h0321, 14'h0200, 8'h00, 8'h00, 0, 8'hEE, 0, 0, 14'h0321, 8'h00, 0, 2'b01, 2'b01, 2'b01, 8'h00, 8'h00, 1), "wd_fire");
    run_vec(v(0, 2'b00, 2'b00, 14'h0321, 14'h0200, 8'h00, 8'h00, 0, 8'hEE, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0), "wd_idle");

    // Timeout advanced rr_ptr, so M1 wins; then reset hits mid-BUSY.
    run_vec(v(0, 2'b11, 2'b00, 14'h0321, 14'h0444, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0), "rst_arb");
    run_vec(v(0, 2'b11, 2'b00, 14'h0321, 14'h0444, 8'h00, 8'h00, 0, 8'h00, 0, 1, 14'h0444, 8'h00, 0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 0), "rst_busy");
    ready_i = 1'b1;
    rdata_i = 8'h5A;
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async", dut_out(), {OW{1'b0}}, {OW{1'b1}});
    @(posedge clk);
    #1;
    run_vec(v(1, 2'b11, 2'b00, 14'h0321, 14'h0444, 8'h00, 8'h00, 1, 8'h5A, 1, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0), "rst_hold");
    run_vec(v(0, 2'b11, 2'b00, 14'h0321, 14'h0444, 8'h00, 8'h00, 0, 8'h00, 0, 0, 14'h0, 8'h0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0), "rst_rel");
    run_vec(v(0, 2'b11, 2'b00, 14'h0321, 14'h0444, 8'h00, 8'h00, 1, 8'h5A, 0, 1, 14'h0321, 8'h00, 0, 2'b01, 2'b01, 2'b00, 8'h5A, 8'h00, 0), "rst_m0");
    run_vec(z, "end_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
